rc4_core_scheduler: RTL and testbench
=====================================

// Module: rc4_core_scheduler
// PURPOSE
//  Shares the 24-bit RC4 key space among NUM_CORES parallel key-search/decrypt cores.
//  Hands out fixed-size key chunks on request, using round-robin arbitration.
//  Latches the first reported hit and broadcasts stop to all cores.
//  Flags no_sol once the space is exhausted and every core is idle; sits between top-level control and the core array.
// PARAMETERS
//  NUM_CORES   4          number of search cores (2..8)
//  CHUNK_LOG2  12         log2 of keys per chunk
//  KEY_START   24'h000000 first key searched
//  KEY_END     24'h3FFFFF last key searched (inclusive)
// PORTS
//  clk         in   1               system clock
//  reset       in   1               async, active-high
//  start       in   1               begin search (sampled in IDLE only)
//  core_req    in   NUM_CORES       core idle and wants a chunk (level)
//  core_busy   in   NUM_CORES       core currently searching a chunk
//  core_found  in   NUM_CORES       1-cycle pulse: core found valid key
//  core_key    in   NUM_CORES*24    per-core found key, slice i = [24*i +: 24]
//  core_grant  out  NUM_CORES       one-hot 1-cycle grant
//  chunk_first out  24              first key of granted chunk (valid with grant)
//  chunk_last  out  24              last key of granted chunk, clamped to KEY_END
//  stop_all    out  1               level: all cores abort
//  found       out  1               level: key found
//  found_key   out  24              latched winning key
//  found_core  out  $clog2(NUM_CORES) index of winning core
//  no_sol      out  1               level: space exhausted, no hit
//  busy        out  1               search in progress
// BEHAVIOUR
//  Reset: state=IDLE, next_key=KEY_START; all outputs 0.
//  FSM:
//   IDLE     -> DISPATCH on start.
//   DISPATCH -> FOUND on any core_found.
//               Else -> DRAIN when next_key > KEY_END (space exhausted).
//   DRAIN    -> FOUND on core_found; -> NO_SOL when core_busy==0 and no grant pending.
//   FOUND, NO_SOL: terminal until reset; start is ignored.
//  Grant rule (DISPATCH only, not in a cycle where core_found seen):
//   - At most one grant per cycle, chosen round-robin from the last granted index + 1.
//   - Registered outputs: grant, chunk_first=next_key, chunk_last=min(next_key+2^CHUNK_LOG2-1, KEY_END).
//   - next_key += 2^CHUNK_LOG2, computed in 25 bits so the carry at 24'hFFFFFF is detected as exhausted.
//   - A core must not be granted in the cycle after its own grant; its req is masked for 1 cycle.
//  Hits:
//   - Simultaneous core_found: the lowest index wins.
//   - found_key/found_core latch in the same edge as the FOUND transition.
//   - found and stop_all assert 1 cycle after the pulse.
//   - core_found outside DISPATCH/DRAIN is ignored.
//  NO_SOL: no_sol=1, stop_all=1, busy=0.
//  busy=1 in DISPATCH and DRAIN.
//  Last chunk: chunk_last is clamped to KEY_END even if the chunk is partial.
//  Reset mid-search: immediate return to IDLE, all latches cleared.
// CONFIGURATION
//  RC4_SCHED_PERF_EN defined: adds outputs perf_chunks [15:0] (grants issued, saturating)
//   and perf_cycles [31:0] (cycles spent busy, saturating); both cleared by reset.
//  Not defined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  rc4_sched_pkg: state enum (IDLE, DISPATCH, DRAIN, FOUND, NO_SOL), KEY_W=24, key_t typedef.
//  Sub-module rr_arbiter #(N): req, mask, last-grant pointer -> one-hot grant + index.
//  Top: FSM, next_key counter, hit latch, priority encoder for core_found.
// TESTING
//  1. NUM_CORES=4, CHUNK_LOG2=12; start, all req=1 -> grants to cores 0,1,2,3,0 on consecutive
//     grant cycles; chunk_first=000000,001000,002000,003000,004000.
//  2. core 2 pulses core_found, key=24'h0ABCDE -> next cycle found=1, stop_all=1,
//     found_key=0ABCDE, found_core=2, no further grants.
//  3. Cores 1 and 3 pulse found together -> found_core=1, and found_key is core 1's key.
//  4. KEY_END=24'h002800 -> third chunk has chunk_first=002000, chunk_last=002800; then DRAIN;
//     drop core_busy to 0 -> no_sol=1 next cycle, busy=0.
//  5. KEY_END=24'hFFFFFF, KEY_START=24'hFFF000 -> single chunk ending FFFFFF;
//     no wrap to 000000; then DRAIN.
//  6. Assert reset mid-DISPATCH -> all outputs 0 asynchronously; a new start restarts at KEY_START.
//  7. Under RC4_SCHED_PERF_EN, scenario 1 with 5 grants -> perf_chunks=5.

Source files
------------

// File: rtl/rc4_core_scheduler_pkg.sv
// Shared types for the RC4 key-space scheduler: FSM states and key width.
package rc4_sched_pkg;

  localparam int KEY_W = 24;

  typedef logic [KEY_W-1:0] key_t;

  typedef enum logic [2:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    FOUND,
    NO_SOL
  } state_t;

endpackage

// File: rtl/rc4_core_scheduler_if.sv
// Scheduler <-> core-array bundle: requests, status and hits in; grants and chunk bounds out.
interface rc4_core_scheduler_if #(
  parameter int NUM_CORES = 4
);
  import rc4_sched_pkg::*;

  logic [NUM_CORES-1:0]       core_req;
  logic [NUM_CORES-1:0]       core_busy;
  logic [NUM_CORES-1:0]       core_found;
  logic [NUM_CORES*KEY_W-1:0] core_key;
  logic [NUM_CORES-1:0]       core_grant;
  key_t                       chunk_first;
  key_t                       chunk_last;

  modport master (
    input  core_req,
    input  core_busy,
    input  core_found,
    input  core_key,
    output core_grant,
    output chunk_first,
    output chunk_last
  );

  modport slave (
    output core_req,
    output core_busy,
    output core_found,
    output core_key,
    input  core_grant,
    input  chunk_first,
    input  chunk_last
  );

endinterface

// File: rtl/rc4_core_scheduler_rr_arbiter.sv
// Round-robin arbiter: search starts at the index after i_last, masked requests skipped.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [N-1:0]  i_mask,
  input  logic [IW-1:0] i_last,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_valid
);

  logic [N-1:0] w_elig;

  assign w_elig = i_req & ~i_mask;

  // Two ascending passes (above the pointer, then wrap) keep every select index constant.
  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!o_valid && w_elig[i] && (i > 32'(i_last))) begin
        o_valid  = 1'b1;
        o_gnt[i] = 1'b1;
        o_idx    = IW'(i);
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!o_valid && w_elig[i] && (i <= 32'(i_last))) begin
        o_valid  = 1'b1;
        o_gnt[i] = 1'b1;
        o_idx    = IW'(i);
      end
    end
  end

endmodule

// File: rtl/rc4_core_scheduler.sv
// RC4 key-space scheduler: hands out key chunks round-robin, latches the first hit, flags exhaustion.
// Optional RC4_SCHED_PERF_EN adds saturating grant/busy-cycle counters.
module rc4_core_scheduler
  import rc4_sched_pkg::*;
#(
  parameter int   NUM_CORES  = 4,
  parameter int   CHUNK_LOG2 = 12,
  parameter key_t KEY_START  = 24'h000000,
  parameter key_t KEY_END    = 24'h3FFFFF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  rc4_core_scheduler_if.master         cif,
  output logic                         stop_all,
  output logic                         found,
  output key_t                         found_key,
  output logic [$clog2(NUM_CORES)-1:0] found_core,
  output logic                         no_sol,
  output logic                         busy
`ifdef RC4_SCHED_PERF_EN
  ,
  output logic [15:0]                  perf_chunks,
  output logic [31:0]                  perf_cycles
`endif
);

  localparam int IW = $clog2(NUM_CORES);
  localparam logic [KEY_W:0] ONE_X   = (KEY_W+1)'(1);
  localparam logic [KEY_W:0] CHUNK_X = ONE_X << CHUNK_LOG2;
  localparam logic [KEY_W:0] END_X   = {1'b0, KEY_END};

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [KEY_W:0]         r_next_key;
  logic [NUM_CORES-1:0]   r_grant;
  key_t                   r_chunk_first;
  key_t                   r_chunk_last;
  logic [IW-1:0]          r_last_idx;
  key_t                   r_found_key;
  logic [IW-1:0]          r_found_core;

  logic                   w_hit;
  logic [IW-1:0]          w_hit_idx;
  key_t                   w_hit_key;
  logic                   w_searching;
  logic                   w_exhausted;
  logic [NUM_CORES-1:0]   w_arb_gnt;
  logic [IW-1:0]          w_arb_idx;
  logic                   w_arb_valid;
  logic                   w_do_grant;
  logic [KEY_W:0]         w_chunk_end;
  key_t                   w_chunk_last;

  rr_arbiter #(
    .N  (NUM_CORES),
    .IW (IW)
  ) u_arb (
    .i_req   (cif.core_req),
    .i_mask  (r_grant),
    .i_last  (r_last_idx),
    .o_gnt   (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_valid (w_arb_valid)
  );

  // Lowest-index core wins when several hits arrive in the same cycle.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    w_hit_key = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!w_hit && cif.core_found[i]) begin
        w_hit     = 1'b1;
        w_hit_idx = IW'(i);
        w_hit_key = cif.core_key[i*KEY_W +: KEY_W];
      end
    end
  end

  // 25-bit key arithmetic so a chunk ending at FFFFFF carries out instead of wrapping.
  assign w_searching  = (r_state == DISPATCH) || (r_state == DRAIN);
  assign w_exhausted  = (r_next_key > END_X);
  assign w_chunk_end  = r_next_key + CHUNK_X - ONE_X;
  assign w_chunk_last = (w_chunk_end > END_X) ? KEY_END : w_chunk_end[KEY_W-1:0];
  assign w_do_grant   = (r_state == DISPATCH) && !w_hit && !w_exhausted && w_arb_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) w_state_nxt = DISPATCH;
      end
      DISPATCH: begin
        if (w_hit)            w_state_nxt = FOUND;
        else if (w_exhausted) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_hit) w_state_nxt = FOUND;
        else if ((cif.core_busy == '0) && (r_grant == '0)) w_state_nxt = NO_SOL;
      end
      default: w_state_nxt = r_state;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_next_key    <= {1'b0, KEY_START};
      r_grant       <= '0;
      r_chunk_first <= '0;
      r_chunk_last  <= '0;
      r_last_idx    <= IW'(NUM_CORES - 1);
      r_found_key   <= '0;
      r_found_core  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= '0;
      if (w_do_grant) begin
        r_grant       <= w_arb_gnt;
        r_chunk_first <= r_next_key[KEY_W-1:0];
        r_chunk_last  <= w_chunk_last;
        r_last_idx    <= w_arb_idx;
        r_next_key    <= r_next_key + CHUNK_X;
      end
      if (w_hit && w_searching) begin
        r_found_key  <= w_hit_key;
        r_found_core <= w_hit_idx;
      end
    end
  end

  assign cif.core_grant  = r_grant;
  assign cif.chunk_first = r_chunk_first;
  assign cif.chunk_last  = r_chunk_last;
  assign found           = (r_state == FOUND);
  assign no_sol          = (r_state == NO_SOL);
  assign stop_all        = found || no_sol;
  assign busy            = w_searching;
  assign found_key       = r_found_key;
  assign found_core      = r_found_core;

`ifdef RC4_SCHED_PERF_EN
  logic [15:0] r_perf_chunks;
  logic [31:0] r_perf_cycles;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_chunks <= '0;
      r_perf_cycles <= '0;
    end else begin
      if (w_do_grant && (r_perf_chunks != '1)) r_perf_chunks <= r_perf_chunks + 16'd1;
      if (w_searching && (r_perf_cycles != '1)) r_perf_cycles <= r_perf_cycles + 32'd1;
    end
  end

  assign perf_chunks = r_perf_chunks;
  assign perf_cycles = r_perf_cycles;
`else
  // Counters absent in this build.
`endif

endmodule

// File: tb/tb_rc4_core_scheduler.sv
// Directed bench for rc4_core_scheduler: three instances cover default, short and top-of-space key ranges.
module tb_rc4_core_scheduler;
  import rc4_sched_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start0, start1, start2;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic       stop0, found0, no_sol0, busy0;
  logic       stop1, found1, no_sol1, busy1;
  logic       stop2, found2, no_sol2, busy2;
  key_t       fkey0, fkey1, fkey2;
  logic [1:0] fcore0, fcore1, fcore2;
`ifdef RC4_SCHED_PERF_EN
  logic [15:0] pch0, pch1, pch2;
  logic [31:0] pcy0, pcy1, pcy2;
`endif

  rc4_core_scheduler_if #(.NUM_CORES(4)) if0();
  rc4_core_scheduler_if #(.NUM_CORES(4)) if1();
  rc4_core_scheduler_if #(.NUM_CORES(4)) if2();

  rc4_core_scheduler #(.NUM_CORES(4), .CHUNK_LOG2(12),
                       .KEY_START(24'h000000), .KEY_END(24'h3FFFFF)) u0 (
    .clk(clk), .reset(reset), .start(start0), .cif(if0),
    .stop_all(stop0), .found(found0), .found_key(fkey0), .found_core(fcore0),
    .no_sol(no_sol0), .busy(busy0)
`ifdef RC4_SCHED_PERF_EN
    , .perf_chunks(pch0), .perf_cycles(pcy0)
`endif
  );

  rc4_core_scheduler #(.NUM_CORES(4), .CHUNK_LOG2(12),
                       .KEY_START(24'h000000), .KEY_END(24'h002800)) u1 (
    .clk(clk), .reset(reset), .start(start1), .cif(if1),
    .stop_all(stop1), .found(found1), .found_key(fkey1), .found_core(fcore1),
    .no_sol(no_sol1), .busy(busy1)
`ifdef RC4_SCHED_PERF_EN
    , .perf_chunks(pch1), .perf_cycles(pcy1)
`endif
  );

  rc4_core_scheduler #(.NUM_CORES(4), .CHUNK_LOG2(12),
                       .KEY_START(24'hFFF000), .KEY_END(24'hFFFFFF)) u2 (
    .clk(clk), .reset(reset), .start(start2), .cif(if2),
    .stop_all(stop2), .found(found2), .found_key(fkey2), .found_core(fcore2),
    .no_sol(no_sol2), .busy(busy2)
`ifdef RC4_SCHED_PERF_EN
    , .perf_chunks(pch2), .perf_cycles(pcy2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] g;
    logic [3:0] acc;

    reset  = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    if0.core_req = '0; if0.core_busy = '0; if0.core_found = '0; if0.core_key = '0;
    if1.core_req = '0; if1.core_busy = '0; if1.core_found = '0; if1.core_key = '0;
    if2.core_req = '0; if2.core_busy = '0; if2.core_found = '0; if2.core_key = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    check("rst grant",    32'(if0.core_grant), 32'h0);
    check("rst busy",     32'(busy0),          32'h0);
    check("rst stop_all", 32'(stop0),          32'h0);
    check("rst found",    32'(found0),         32'h0);
    check("rst no_sol",   32'(no_sol0),        32'h0);
    check("rst fkey",     32'(fkey0),          32'h0);

    // 1: round-robin over all requesting cores, consecutive chunks
    if0.core_req = 4'b1111;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    check("t1 busy", 32'(busy0), 32'h1);
    check("t1 no early grant", 32'(if0.core_grant), 32'h0);
    for (int k = 0; k < 5; k++) begin
      tick();
      g = 4'b0001 << (k % 4);
      check($sformatf("t1 grant%0d", k), 32'(if0.core_grant), 32'(g));
      check($sformatf("t1 first%0d", k), 32'(if0.chunk_first), 32'(k * 4096));
      check($sformatf("t1 last%0d", k),  32'(if0.chunk_last),  32'(k * 4096 + 4095));
    end
`ifdef RC4_SCHED_PERF_EN
    check("t7 perf_chunks", 32'(pch0), 32'd5);
    check("t7 perf_cycles", pcy0, 32'd5);
`endif

    // 2: core 2 reports a hit
    if0.core_found = 4'b0100;
    if0.core_key[2*24 +: 24] = 24'h0ABCDE;
    check("t2 found latency", 32'(found0), 32'h0);
    tick();
    if0.core_found = '0;
    check("t2 found",      32'(found0),         32'h1);
    check("t2 stop_all",   32'(stop0),          32'h1);
    check("t2 found_key",  32'(fkey0),          32'h0ABCDE);
    check("t2 found_core", 32'(fcore0),         32'h2);
    check("t2 grant",      32'(if0.core_grant), 32'h0);
    check("t2 busy",       32'(busy0),          32'h0);
    start0 = 1'b1;
    acc = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      acc = acc | if0.core_grant;
    end
    start0 = 1'b0;
    check("t2 no more grants", 32'(acc),   32'h0);
    check("t2 found sticky",   32'(found0), 32'h1);

    // async reset clears the hit latch without a clock edge
    reset = 1'b1;
    #2;
    check("arst found",      32'(found0), 32'h0);
    check("arst stop_all",   32'(stop0),  32'h0);
    check("arst found_key",  32'(fkey0),  32'h0);
    check("arst found_core", 32'(fcore0), 32'h0);
    tick();
    reset = 1'b0;

    // 3: simultaneous hits from cores 1 and 3
    if0.core_req = '0;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    if0.core_key = '0;
    if0.core_key[1*24 +: 24] = 24'h111111;
    if0.core_key[3*24 +: 24] = 24'h333333;
    if0.core_found = 4'b1010;
    tick();
    if0.core_found = '0;
    check("t3 found",      32'(found0), 32'h1);
    check("t3 found_core", 32'(fcore0), 32'h1);
    check("t3 found_key",  32'(fkey0),  32'h111111);

    // 6: reset mid-DISPATCH, then restart; single requester exercises the 1-cycle mask
    reset = 1'b1;
    #2;
    tick();
    reset = 1'b0;
    if0.core_req = 4'b1111;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    tick();
    check("t6 pre grant", 32'(if0.core_grant), 32'h2);
    reset = 1'b1;
    #2;
    check("t6 arst busy",  32'(busy0),           32'h0);
    check("t6 arst grant", 32'(if0.core_grant),  32'h0);
    check("t6 arst first", 32'(if0.chunk_first), 32'h0);
    check("t6 arst stop",  32'(stop0),           32'h0);
    tick();
    reset = 1'b0;
    if0.core_req = 4'b0001;
    start0 = 1'b1;
    tick();
    start0 = 1'b0;
    tick();
    check("t6 restart grant", 32'(if0.core_grant),  32'h1);
    check("t6 restart first", 32'(if0.chunk_first), 32'h000000);
    tick();
    check("t6 masked", 32'(if0.core_grant), 32'h0);
    tick();
    check("t6 regrant",       32'(if0.core_grant),  32'h1);
    check("t6 regrant first", 32'(if0.chunk_first), 32'h001000);

    // 4: short space, clamped partial last chunk, drain then no_sol
    if1.core_req  = 4'b1111;
    if1.core_busy = 4'b1111;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();
    check("t4 g0 last", 32'(if1.chunk_last), 32'h000FFF);
    tick();
    check("t4 g1 first", 32'(if1.chunk_first), 32'h001000);
    tick();
    check("t4 g2 grant", 32'(if1.core_grant),  32'h4);
    check("t4 g2 first", 32'(if1.chunk_first), 32'h002000);
    check("t4 g2 last",  32'(if1.chunk_last),  32'h002800);
    tick();
    check("t4 drain no grant", 32'(if1.core_grant), 32'h0);
    check("t4 drain busy",     32'(busy1),          32'h1);
    tick();
    check("t4 drain hold", 32'(no_sol1), 32'h0);
    if1.core_busy = '0;
    tick();
    check("t4 no_sol",   32'(no_sol1), 32'h1);
    check("t4 stop_all", 32'(stop1),   32'h1);
    check("t4 busy",     32'(busy1),   32'h0);
    check("t4 found",    32'(found1),  32'h0);

    // 5: top of key space, no wrap past FFFFFF
    if2.core_req = 4'b1111;
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    tick();
    check("t5 grant", 32'(if2.core_grant),  32'h1);
    check("t5 first", 32'(if2.chunk_first), 32'hFFF000);
    check("t5 last",  32'(if2.chunk_last),  32'hFFFFFF);
    tick();
    check("t5 no wrap grant", 32'(if2.core_grant), 32'h0);
    check("t5 drain busy",    32'(busy2),          32'h1);
    check("t5 drain no_sol",  32'(no_sol2),        32'h0);
    tick();
    check("t5 no_sol", 32'(no_sol2), 32'h1);
    check("t5 busy",   32'(busy2),   32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
